// File: rtl/cpsr_tracker_pkg.sv
// rtl/cpsr_tracker_pkg.sv - shared flag layout, condition prefix and helper for cpsr_tracker
package cpsr_tracker_pkg;

    // Width of the architectural flag nibble.
    localparam int FLAG_W = 4;

    // Condition codes 4'b1110 and 4'b1111 execute unconditionally.
    localparam logic [2:0] COND_AL = 3'b111;

    // Flag nibble layout, MSB first: V=bit3, N=bit2, C=bit1, Z=bit0.
    typedef struct packed {
        logic v;
        logic n;
        logic c;
        logic z;
    } flags_t;

    // True when the condition field needs the flags to resolve.
    // Bit 0 is folded in so the whole field is read; it does not affect the result.
    function automatic logic uses_flags(input logic [3:0] cond);
        return (cond | 4'b0001) != {COND_AL, 1'b1};
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// rtl/sat_updown_counter.sv - saturating up/down counter with underflow flag
module sat_updown_counter #(
    parameter int WIDTH = 2,
    parameter int MAX   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             underflow_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: simultaneous inc and dec cancel; never wraps at either end.
    always_comb begin
        count_d     = count_q;
        underflow_o = dec_i & ~inc_i & (count_q == '0);
        if (inc_i & ~dec_i) begin
            if (count_q != WIDTH'(MAX)) begin
                count_d = count_q + 1'b1;
            end
        end else if (dec_i & ~inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpsr_tracker.sv
// rtl/cpsr_tracker.sv - CPSR flag register with in-flight flag-writer tracking; optional CPSR_BYPASS_EN
module cpsr_tracker
    import cpsr_tracker_pkg::*;
#(
    parameter  int MAX_PENDING = 3,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic              clkin,
    input  logic              resetin,
    input  logic              issuevalidin,
    input  logic [3:0]        issuecondin,
    input  logic              issuesetflagsin,
    output logic              stallout,
    input  logic              wbvalidin,
    input  logic [FLAG_W-1:0] wbflagsin,
    output logic [FLAG_W-1:0] cpsrout,
    output logic [CNT_W-1:0]  pendingout,
    output logic              errout
);

    flags_t           cpsr_q;
    logic             err_q;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] pend_eff;
    logic             usesflags;
    logic             full;
    logic             accept_set;
    logic             underflow;

    assign usesflags = uses_flags(issuecondin);
    assign full      = (pending == CNT_W'(MAX_PENDING));

`ifdef CPSR_BYPASS_EN
    // A write retiring this cycle no longer blocks a conditional reader,
    // because its flags are forwarded straight onto cpsrout.
    assign pend_eff = (wbvalidin && pending != '0) ? pending - 1'b1 : pending;
    assign cpsrout  = wbvalidin ? wbflagsin : cpsr_q;
`else
    assign pend_eff = pending;
    assign cpsrout  = cpsr_q;
`endif

    // Full check uses the raw count: a same-cycle writeback does not free a slot early.
    assign stallout   = issuevalidin &
                        ((usesflags & (pend_eff != '0)) | (issuesetflagsin & full));
    assign accept_set = issuevalidin & ~stallout & issuesetflagsin;

    sat_updown_counter #(
        .WIDTH (CNT_W),
        .MAX   (MAX_PENDING)
    ) u_pending (
        .clk_i       (clkin),
        .rst_i       (resetin),
        .inc_i       (accept_set),
        .dec_i       (wbvalidin),
        .count_o     (pending),
        .underflow_o (underflow)
    );

    // Architectural flags take every writeback, even an unexpected one.
    always_ff @(posedge clkin) begin
        if (resetin) begin
            cpsr_q <= '0;
        end else if (wbvalidin) begin
            cpsr_q <= wbflagsin;
        end
    end

    // Sticky error: a writeback arrived with nothing outstanding.
    always_ff @(posedge clkin) begin
        if (resetin) begin
            err_q <= 1'b0;
        end else if (underflow) begin
            err_q <= 1'b1;
        end
    end

    assign pendingout = pending;
    assign errout     = err_q;

endmodule
